// File: rtl/aes_key_expand.sv
// aes_key_expand: FIPS-197 key schedule generator for AES-128/192/256.
// Loads the cipher key on start_i, then derives one 32-bit schedule word per cycle into
// an internal word store. Round keys are read by index with one cycle of registered latency.
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   start_i         single-cycle request to load key_in_i and expand
//   key_in_i        cipher key, w0 in the top 32 bits; unused low bits ignored
//   key_len_i       0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = invalid
//   round_key_no_i  round key index requested by the cipher
//   round_key_o     {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r sampled on the previous edge
//   rounds_total_o  Nr (10/12/14) of the loaded key
//   ready_o         schedule complete and valid
//   busy_o          expansion in progress
//   err_o           one-cycle pulse after a start with key_len_i = 3
module aes_key_expand #(
    parameter int unsigned KEY_S     = 256,
    parameter int unsigned MAX_WORDS = 60
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [KEY_S-1:0] key_in_i,
    input  logic [1:0]       key_len_i,
    input  logic [3:0]       round_key_no_i,
    output logic [127:0]     round_key_o,
    output logic [3:0]       rounds_total_o,
    output logic             ready_o,
    output logic             busy_o,
    output logic             err_o
);

    // AES S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x sits at bit offset 8*(255-x) = 8*~x.
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    typedef enum logic [1:0] {StIdle, StExpand, StDone} state_e;

    state_e         state_q, state_d;
    logic [3:0]     nk_q, nr_q;
    logic [5:0]     wtot_q, i_q;
    logic [2:0]     mod_q;
    logic [7:0]     rcon_q;
    logic           err_q;
    logic [127:0]   round_key_q, round_key_d;
    logic [31:0]    store_q [MAX_WORDS];

    logic           load, bad, last;
    logic [3:0]     nk_new, nr_new;
    logic [5:0]     wtot_new;
    logic [31:0]    prev_w, back_w, sub_in, sub_w, temp_w, new_w;
    logic [7:0]     rcon_next;

    assign load     = start_i && (state_q != StExpand) && (key_len_i != 2'd3);
    assign bad      = start_i && (state_q != StExpand) && (key_len_i == 2'd3);
    assign last     = (state_q == StExpand) && (i_q == wtot_q - 6'd1);
    assign nk_new   = 4'd4 + {1'b0, key_len_i, 1'b0};
    assign nr_new   = nk_new + 4'd6;
    assign wtot_new = {nr_new + 4'd1, 2'b00};

    // Schedule word datapath for word i_q.
    always_comb begin
        prev_w    = store_q[i_q - 6'd1];
        back_w    = store_q[i_q - {2'b00, nk_q}];
        sub_in    = (mod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
        sub_w     = sub_word(sub_in);
        rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (mod_q == 3'd0) begin
            temp_w = sub_w ^ {rcon_q, 24'h0};
        end else if (nk_q == 4'd8 && mod_q == 3'd4) begin
            temp_w = sub_w;
        end else begin
            temp_w = prev_w;
        end
        new_w = back_w ^ temp_w;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: if (load) state_d = StExpand;
            StExpand:       if (last) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        ready_o        = (state_q == StDone);
        busy_o         = (state_q == StExpand);
        err_o          = err_q;
        rounds_total_o = nr_q;
        round_key_o    = round_key_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nk_q   <= 4'd0;
            nr_q   <= 4'd0;
            wtot_q <= 6'd0;
            i_q    <= 6'd0;
            mod_q  <= 3'd0;
            rcon_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            err_q <= bad;
            if (load) begin
                nk_q   <= nk_new;
                nr_q   <= nr_new;
                wtot_q <= wtot_new;
                i_q    <= {2'b00, nk_new};
                mod_q  <= 3'd0;
                rcon_q <= 8'h01;
            end else if (state_q == StExpand) begin
                i_q <= i_q + 6'd1;
                // Nk-1 in 3 bits: 3, 5, or 7 (Nk = 8 wraps to 0, minus one gives 7).
                mod_q <= (mod_q == nk_q[2:0] - 3'd1) ? 3'd0 : mod_q + 3'd1;
                if (mod_q == 3'd0) rcon_q <= rcon_next;
            end
        end
    end

    // Word store has no reset; its contents are only trusted once ready_o is set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (load) begin
                for (int j = 0; j < 8; j++) begin
                    if (j < int'(nk_new)) store_q[6'(j)] <= key_in_i[KEY_S-1-32*j -: 32];
                end
            end else if (state_q == StExpand) begin
                store_q[i_q] <= new_w;
            end
        end
    end

    // Round key read; indices beyond the store return zero and never touch it.
    always_comb begin
        logic [5:0] idx;
        round_key_d = '0;
        for (int j = 0; j < 4; j++) begin
            idx = {round_key_no_i, 2'(j)};
            if (int'(idx) < int'(MAX_WORDS)) round_key_d[127-32*j -: 32] = store_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) round_key_q <= '0;
        else       round_key_q <= round_key_d;
    end

endmodule
